// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M multiply/divide unit, one result bit per cycle
// Shift-add multiply and restoring divide share the acc/lo/opnd registers; signs are fixed up on the last step.
module alu_muldiv #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_operand_a,
   input  logic [DATA_W-1:0] i_operand_b,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_result_ready,
   output logic [DATA_W-1:0] o_result,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [TAG_W-1:0]    otag_q, otag_d;

   logic                accept, a_signed, b_signed, sa, sb, div_zero, div_ovf;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     mul_sum, shifted;
   logic [2*DATA_W-1:0] prod_nxt, prod_fix;
   logic                ge;
   logic [DATA_W-1:0]   rem_nxt, quo_nxt, rem_fix, quo_fix, final_res;

   assign o_ready  = (state_q == S_IDLE) && !i_flush;
   assign o_busy   = (state_q != S_IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;
   assign o_tag    = otag_q;
   assign accept   = i_valid && o_ready;

   always_comb begin
      a_signed = (i_op == 3'd0) || (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
      b_signed = (i_op == 3'd0) || (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
      sa       = a_signed && i_operand_a[DATA_W-1];
      sb       = b_signed && i_operand_b[DATA_W-1];
      a_mag    = sa ? -i_operand_a : i_operand_a;
      b_mag    = sb ? -i_operand_b : i_operand_b;
      div_zero = (i_operand_b == '0);
      div_ovf  = !i_op[0] && (i_operand_a == MIN_V) && (i_operand_b == '1);
   end

   // One iteration of each algorithm; lo holds the multiplier or the dividend being shifted out.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
      prod_nxt = {mul_sum, lo_q[DATA_W-1:1]};
      shifted  = {acc_q, lo_q[DATA_W-1]};
      ge       = (shifted >= {1'b0, opnd_q});
      rem_nxt  = ge ? (shifted[DATA_W-1:0] - opnd_q) : shifted[DATA_W-1:0];
      quo_nxt  = {lo_q[DATA_W-2:0], ge};
      prod_fix = (neg_a_q ^ neg_b_q) ? -prod_nxt : prod_nxt;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_nxt : quo_nxt;
      rem_fix  = neg_a_q ? -rem_nxt : rem_nxt;
      final_res = prod_fix[DATA_W-1:0];
      case (op_q)
         3'd1, 3'd2, 3'd3: final_res = prod_fix[2*DATA_W-1:DATA_W];
         3'd4, 3'd5:       final_res = quo_fix;
         3'd6, 3'd7:       final_res = rem_fix;
         default:          final_res = prod_fix[DATA_W-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tag_d    = tag_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      valid_d  = valid_q;
      result_d = result_q;
      otag_d   = otag_q;
      if (i_flush) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               op_d    = i_op;
               tag_d   = i_tag;
               neg_a_d = sa;
               neg_b_d = sb;
               if (i_op[2] && (div_zero || div_ovf)) begin
                  if (div_zero) result_d = i_op[1] ? i_operand_a : '1;
                  else          result_d = i_op[1] ? '0 : i_operand_a;
                  otag_d  = i_tag;
                  valid_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = CNT_W'(DATA_W - 1);
                  acc_d   = '0;
                  lo_d    = i_op[2] ? a_mag : b_mag;
                  opnd_d  = i_op[2] ? b_mag : a_mag;
                  state_d = S_CALC;
               end
            end
            S_CALC: begin
               if (op_q[2]) begin
                  acc_d = rem_nxt;
                  lo_d  = quo_nxt;
               end else begin
                  {acc_d, lo_d} = prod_nxt;
               end
               if (cnt_q == '0) begin
                  result_d = final_res;
                  otag_d   = tag_q;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_DONE: if (i_result_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         tag_q    <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         otag_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         otag_q   <= otag_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - randomized bench for alu_muldiv at DATA_W=32 and DATA_W=8 against an arithmetic model
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst, valid, sel8, flush, rr;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  tag;
   int          total = 0;
   int          bad = 0;

   logic        ready32, ov32, busy32, ready8, ov8, busy8;
   logic [31:0] res32;
   logic [7:0]  res8;
   logic [4:0]  tag32, tag8;
   logic        cur_ready, cur_valid, cur_busy;
   logic [31:0] cur_res;
   logic [4:0]  cur_tag;

   always #5 clk = ~clk;

   alu_muldiv #(.DATA_W(32), .TAG_W(5)) dut32 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid && !sel8), .o_ready(ready32), .i_op(op),
      .i_operand_a(a), .i_operand_b(b), .i_tag(tag), .i_flush(flush), .o_valid(ov32),
      .i_result_ready(rr), .o_result(res32), .o_tag(tag32), .o_busy(busy32));

   alu_muldiv #(.DATA_W(8), .TAG_W(5)) dut8 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid && sel8), .o_ready(ready8), .i_op(op),
      .i_operand_a(a[7:0]), .i_operand_b(b[7:0]), .i_tag(tag), .i_flush(flush), .o_valid(ov8),
      .i_result_ready(rr), .o_result(res8), .o_tag(tag8), .o_busy(busy8));

   always_comb begin
      if (sel8) begin
         cur_ready = ready8; cur_valid = ov8; cur_busy = busy8; cur_res = {24'b0, res8}; cur_tag = tag8;
      end else begin
         cur_ready = ready32; cur_valid = ov32; cur_busy = busy32; cur_res = res32; cur_tag = tag32;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] mask, ua, ub, p;
      longint      sa, sb, minv;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'b0, x} & mask;
      ub   = {32'b0, y} & mask;
      sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      minv = -(longint'(1) << (w - 1));
      p    = 64'd0;
      case (o)
         3'd0: p = 64'(sa * sb);
         3'd1: p = 64'(sa * sb) >> w;
         3'd2: p = 64'(sa * longint'(ub)) >> w;
         3'd3: p = (ua * ub) >> w;
         3'd4: p = (ub == 0) ? mask : (sa == minv && sb == -1) ? ua : 64'(sa / sb);
         3'd5: p = (ub == 0) ? mask : ua / ub;
         3'd6: p = (ub == 0) ? ua : (sa == minv && sb == -1) ? 64'd0 : 64'(sa % sb);
         default: p = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(p & mask);
   endfunction

   task automatic start_op(input bit w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      sel8 = w8;
      @(negedge clk);
      op = o; a = x; b = y; tag = 5'd9; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input logic [31:0] exp, input int hold, input string name);
      int          w, n, lat;
      logic [31:0] mask, xx, yy, minv;
      bit          special;
      w    = w8 ? 8 : 32;
      mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
      minv = w8 ? 32'h80 : 32'h8000_0000;
      xx   = x & mask;
      yy   = y & mask;
      special = o[2] && ((yy == 0) || (!o[0] && xx == minv && yy == mask));
      sel8 = w8;
      @(negedge clk);
      n = 0;
      while (!cur_ready && n < 50) begin @(negedge clk); n++; end
      check({name, "_ready"}, 32'(cur_ready), 32'd1);
      op = o; a = x; b = y; tag = t; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; tag = 5'($urandom);
      lat = 0;
      while (!cur_valid && lat < w + 5) begin @(posedge clk); #1; lat++; end
      check({name, "_latency"}, 32'(lat), special ? 32'd0 : 32'(w));
      check({name, "_result"}, cur_res, exp);
      check({name, "_tag"}, 32'(cur_tag), 32'(t));
      check({name, "_busy"}, 32'(cur_busy), 32'd1);
      repeat (hold) begin
         @(posedge clk); #1;
         check({name, "_hold_valid"}, 32'(cur_valid), 32'd1);
         check({name, "_hold_result"}, cur_res, exp);
         check({name, "_hold_ready"}, 32'(cur_ready), 32'd0);
      end
      rr = 1'b1;
      @(posedge clk); #1;
      rr = 1'b0;
      check({name, "_post_valid"}, 32'(cur_valid), 32'd0);
      check({name, "_post_busy"}, 32'(cur_busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      bit          seen;
      logic [2:0]  dop [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] da  [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd33, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] db  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] dx  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [31:0] a8  [12] = '{32'd7, 32'h80, 32'h80, 32'hFF, 32'hF9, 32'hF9, 32'd100, 32'd100, 32'd33, 32'd5, 32'h80, 32'h80};
      logic [31:0] b8  [12] = '{32'hFD, 32'h80, 32'h80, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFF, 32'hFF};

      rst = 1'b1; valid = 1'b0; sel8 = 1'b0; flush = 1'b0; rr = 1'b0;
      op = 3'd0; a = 32'd0; b = 32'd0; tag = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(ov32), 32'd0);
      check("rst_result", res32, 32'd0);
      check("rst_tag", 32'(tag32), 32'd0);
      check("rst_busy", 32'(busy32), 32'd0);
      check("rst_ready", 32'(ready32), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         run_op(1'b0, dop[i], da[i], db[i], 5'(i + 3), dx[i], (i == 0) ? 10 : 0, $sformatf("dir32_%0d", i));
      for (int i = 0; i < 12; i++)
         run_op(1'b1, dop[i], a8[i], b8[i], 5'(i + 17), ref_res(8, dop[i], a8[i], b8[i]), 0, $sformatf("dir8_%0d", i));

      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom);
         ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0080 : $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
         if (i % 2 == 0) run_op(1'b0, ro, ra, rb, 5'($urandom), ref_res(32, ro, ra, rb), 0, $sformatf("rnd32_%0d", i));
         else            run_op(1'b1, ro, ra, rb, 5'($urandom), ref_res(8, ro, ra, rb), 0, $sformatf("rnd8_%0d", i));
      end

      start_op(1'b0, 3'd0, 32'd1234, 32'd5678);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_busy", 32'(busy32), 32'd0);
      check("flush_ready_low", 32'(ready32), 32'd0);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; flush = 1'b0;
      check("flush_beats_accept", 32'(busy32), 32'd0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1'b1; end
      check("flush_no_valid", 32'(seen), 32'd0);

      start_op(1'b0, 3'd4, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(ov32), 32'd0);
      check("arst_busy", 32'(busy32), 32'd0);
      check("arst_result", res32, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1'b1; end
      check("arst_no_valid", 32'(seen), 32'd0);
      run_op(1'b0, 3'd3, 32'd3, 32'd5, 5'd21, 32'd0, 0, "mulhu_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
